// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the framed UART receiver
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, one pulse every i_div+1 clocks
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] r_cnt;

    assign o_tick = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= i_div;
        end else begin
            r_cnt <= r_cnt - DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_rx_framed.sv
// rtl/uart_rx_framed.sv - oversampling UART receiver with parity, stop checks and held output
module uart_rx_framed #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_rx,
    input  logic [DIV_WIDTH-1:0] i_baud_div,
    input  logic [1:0]           i_parity_mode,
    input  logic                 i_stop2,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);
    import uart_pkg::*;

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_S2   = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

    logic                 r_rx_m, r_rx_s;
    rx_state_t            r_state, w_state_next;
    logic [DIV_WIDTH-1:0] r_div;
    logic [1:0]           r_par_mode;
    logic                 r_stop2;
    logic [TW-1:0]        r_tick_cnt;
    logic [IW-1:0]        r_bit_idx;
    logic [1:0]           r_samp;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_acc, r_par_err, r_ferr;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid, r_out_perr, r_out_ferr, r_overrun;

    logic                 w_tick, w_mid, w_end, w_maj, w_par_en, w_last_stop;
    logic                 w_done, w_done_ferr, w_handshake;
    logic [DIV_WIDTH-1:0] w_div;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
        end else begin
            r_rx_m <= i_rx;
            r_rx_s <= r_rx_m;
        end
    end

    // Live divisor only while idle; the captured copy governs the frame in progress.
    assign w_div = (r_state == ST_IDLE) ? i_baud_div : r_div;

    uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud_tick (
        .clk    (clk),
        .reset  (reset),
        .i_div  (w_div),
        .o_tick (w_tick)
    );

    assign w_mid       = w_tick && (r_tick_cnt == T_S2);
    assign w_end       = w_tick && (r_tick_cnt == T_LAST);
    assign w_maj       = maj3(r_samp[1], r_samp[0], r_rx_s);
    assign w_par_en    = (r_par_mode == PAR_EVEN) || (r_par_mode == PAR_ODD);
    assign w_last_stop = r_stop2 ? (r_bit_idx == IW'(1)) : (r_bit_idx == '0);
    assign w_done_ferr = r_ferr | ~w_maj;
    assign w_handshake = r_valid && i_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick && !r_rx_s) w_state_next = ST_START;
            end
            ST_START: begin
                if (w_mid && w_maj) w_state_next = ST_IDLE;
                else if (w_end)     w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_end && (r_bit_idx == IW'(DATA_BITS - 1)))
                    w_state_next = w_par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_end) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                // Completing at mid-bit leaves half a stop bit to re-arm start detection.
                if (w_mid && w_last_stop) begin
                    w_done       = 1'b1;
                    w_state_next = w_done_ferr ? ST_WAIT_HIGH : ST_IDLE;
                end
            end
            ST_WAIT_HIGH: begin
                if (w_tick && r_rx_s) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_samp     <= '0;
            r_shift    <= '0;
            r_par_acc  <= 1'b0;
            r_par_err  <= 1'b0;
            r_ferr     <= 1'b0;
            r_div      <= '0;
            r_par_mode <= PAR_NONE;
            r_stop2    <= 1'b0;
        end else if (w_tick) begin
            if (r_state == ST_IDLE) begin
                r_tick_cnt <= '0;
                r_bit_idx  <= '0;
                if (!r_rx_s) begin
                    r_div      <= i_baud_div;
                    r_par_mode <= i_parity_mode;
                    r_stop2    <= i_stop2;
                    r_par_acc  <= 1'b0;
                    r_par_err  <= 1'b0;
                    r_ferr     <= 1'b0;
                end
            end else begin
                r_tick_cnt <= (r_tick_cnt == T_LAST) ? '0 : r_tick_cnt + TW'(1);
                if ((r_tick_cnt == T_S0) || (r_tick_cnt == T_S1))
                    r_samp <= {r_samp[0], r_rx_s};
                if (w_mid) begin
                    case (r_state)
                        ST_DATA: begin
                            r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
                            r_par_acc <= r_par_acc ^ w_maj;
                        end
                        ST_PARITY: r_par_err <= (r_par_acc ^ w_maj) != (r_par_mode == PAR_ODD);
                        ST_STOP:   r_ferr    <= w_done_ferr;
                        default:   ;
                    endcase
                end
                if (w_end)
                    r_bit_idx <= (w_state_next != r_state) ? '0 : r_bit_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_out_perr <= 1'b0;
            r_out_ferr <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
            if (w_done) begin
                if (!r_valid || w_handshake) begin
                    r_data     <= r_shift;
                    r_out_perr <= r_par_err;
                    r_out_ferr <= w_done_ferr;
                    r_valid    <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_parity_err = r_out_perr;
    assign o_frame_err  = r_out_ferr;
    assign o_overrun    = r_overrun;
    assign o_busy       = (r_state != ST_IDLE);

endmodule
